// File: rtl/lmac_tx_fcs_insert.sv
// lmac_tx_fcs_insert: forwards one Ethernet frame byte stream, computes CRC-32
// (poly 0x04C11DB7, init all-ones, byte-wide MSB-first LFSR on bit-reversed
// input) and appends the 4-byte FCS, least-significant byte first.
// Optional build macro: LMAC_TX_PAD_EN -- pads short frames with 0x00 up to MIN_LEN.
module lmac_tx_fcs_insert #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [31:0]      fcs_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_len
);

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // MIN_LEN must be reachable by the saturating byte counter
  if (64'(MIN_LEN) >= (64'd1 << CNT_W)) begin : g_min_len_range
    $error("MIN_LEN exceeds byte counter range");
  end

`ifdef LMAC_TX_PAD_EN
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FCS} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FCS} state_e;
`endif

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction

  // Eight MSB-first LFSR shifts; d[7] enters first
  function automatic logic [31:0] step8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[7-i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [31:0]      fcs_out_q, fcs_out_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic             frame_done_q, frame_done_d;
  logic             ready_en_q;

  logic             out_free_c;
  logic             accept_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [31:0]      fcs_c;
  logic [7:0]       fcs_byte_c;

  assign out_free_c = !out_valid_q || out_ready;
  assign in_ready   = ready_en_q && (state_q == S_IDLE || state_q == S_DATA) && out_free_c;
  assign accept_c   = in_valid && in_ready;
  assign cnt_inc_c  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign fcs_c      = ~bitrev32(crc_q);

  // FCS byte for the current transmit index
  always_comb begin
    fcs_byte_c = 8'h00;
    case (idx_q[1:0])
      2'd0:    fcs_byte_c = fcs_c[7:0];
      2'd1:    fcs_byte_c = fcs_c[15:8];
      2'd2:    fcs_byte_c = fcs_c[23:16];
      default: fcs_byte_c = fcs_c[31:24];
    endcase
  end

  // Next-state, CRC, counters and output register load
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    fcs_out_d    = fcs_out_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept_c) begin
          crc_d       = step8(crc_q, bitrev8(in_data));
          cnt_d       = cnt_inc_c;
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          idx_d       = 3'd0;
          state_d     = in_last ? S_FCS : S_DATA;
`ifdef LMAC_TX_PAD_EN
          if (in_last && (cnt_inc_c < MIN_LEN_C)) state_d = S_PAD;
`endif
        end
      end
`ifdef LMAC_TX_PAD_EN
      S_PAD: begin
        if (out_free_c) begin
          crc_d       = step8(crc_q, 8'h00);
          cnt_d       = cnt_inc_c;
          out_data_d  = 8'h00;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          if (cnt_inc_c >= MIN_LEN_C) state_d = S_FCS;
        end
      end
`endif
      S_FCS: begin
        if (out_free_c && (idx_q < 3'd4)) begin
          out_data_d  = fcs_byte_c;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == 3'd3);
          idx_d       = idx_q + 3'd1;
        end
        if (out_valid_q && out_last_q && out_ready) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          fcs_out_d    = fcs_c;
          frame_len_d  = cnt_q;
          crc_d        = CRC_INIT;
          cnt_d        = '0;
          idx_d        = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      fcs_out_q    <= 32'h0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      fcs_out_q    <= fcs_out_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign fcs_out    = fcs_out_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/lmac_tx_fcs_insert.md
Name: lmac_tx_fcs_insert

Overview:
- Transmit-path stage between the TX frame buffer and the MAC byte serializer.
- Accepts one Ethernet frame as a byte stream (DA through payload, FCS excluded).
- Computes CRC-32 per byte with an internal byte-wide LFSR: polynomial 0x04C11DB7, init 0xFFFFFFFF per frame.
- Forwards the frame unchanged, then appends the 4-byte FCS. Raises a per-frame done strobe carrying the FCS.

Parameters:
- MIN_LEN, 60, minimum frame length in bytes excluding FCS; used only when padding is compiled in.
- CNT_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- in_data  in  8  frame byte
- in_valid  in  1  in_data valid
- in_last  in  1  final byte of frame (qualified by in_valid)
- in_ready  out  1  block accepts the byte this cycle
- out_data  out  8  output byte
- out_valid  out  1  out_data valid
- out_last  out  1  final FCS byte
- out_ready  in  1  downstream accepts the byte this cycle
- fcs_out  out  32  FCS of last completed frame, transmit order (fcs_out[7:0] sent first)
- frame_done  out  1  one-cycle pulse when the last FCS byte is accepted
- frame_len  out  CNT_W  bytes sent excluding FCS, valid with frame_done

Behaviour:
- Reset (async assert, sync release): state=IDLE; crc=0xFFFFFFFF; all counters 0.
  - Output reset values: out_valid=0, out_last=0, out_data=0, in_ready=0, frame_done=0, fcs_out=0, frame_len=0.
- Output is a single register stage.
  - A byte is accepted when in_valid and in_ready are both high.
  - It appears on out_data the next cycle.
  - Latency: 1 cycle when out_ready is held high.
  - out_valid holds and out_data is stable while out_ready=0.
- in_ready = (state in IDLE or DATA) and (!out_valid or out_ready).
- CRC update per accepted byte: crc_next = step8(crc, bitrev8(in_data)), MSB-first shift form.
- FCS = ~bitrev32(crc_final). Transmit order: FCS[7:0], FCS[15:8], FCS[23:16], FCS[31:24].
- States:
  - IDLE: crc=0xFFFFFFFF, byte_cnt=0. First accept goes to DATA, or straight to FCS if in_last is set on that byte.
  - DATA: every accept updates crc and increments byte_cnt. An accept with in_last set goes to FCS.
  - FCS: in_ready=0. fcs_idx 0..3 advances on each output handshake. out_last is high with idx 3. Handshake at idx 3 goes to IDLE and pulses frame_done; fcs_out and frame_len are registered in that same cycle.
- Back-to-back frames: a new frame can be accepted the cycle after the final FCS handshake (1 idle cycle minimum).
- byte_cnt saturates at 2^CNT_W-1. The CRC stays correct beyond saturation.
- in_valid while in FCS is ignored (not accepted). Upstream must hold the data.
- Reset mid-frame: the partial frame is discarded and out_valid drops immediately.
- A single-byte frame (in_last on the first byte) is legal: 1 data byte + 4 FCS bytes.

Optional Feature:
- Macro: LMAC_TX_PAD_EN.
- Defined:
  - Adds a PAD state between DATA and FCS.
  - If byte_cnt < MIN_LEN when in_last is accepted, the block emits 0x00 bytes until byte_cnt = MIN_LEN.
  - Pad bytes are included in the CRC and in frame_len.
  - in_ready=0 during PAD.
- Undefined:
  - No PAD state. Short frames pass unpadded.
  - frame_len equals the number of input bytes.

Test Plan:
- ASCII "123456789" (0x31..0x39), out_ready=1.
  - Output: the 9 bytes, then 0x26 0x39 0xF4 0xCB.
  - out_last on 0xCB; fcs_out=0xCBF43926 (transmit order); frame_len=9; frame_done one cycle.
- Same frame with out_ready toggling 1/0 every cycle -> identical byte sequence, no duplicates or drops, out_data stable while stalled.
- Two back-to-back 64-byte incrementing frames (0x00..0x3F) -> each gets an independent FCS matching a reference model; CRC re-initialised between frames.
- Single byte 0x00 with in_last -> 0x00 followed by FCS bytes 0x8D 0xEF 0x02 0xD2 (CRC-32 of 0x00 = 0xD202EF8D).
- rst asserted after 20 bytes of a frame.
  - out_valid=0 asynchronously.
  - The next full frame after release produces a correct FCS.
- LMAC_TX_PAD_EN defined, 10-byte frame -> 50 bytes of 0x00 appended; frame_len=60; FCS computed over all 60 bytes.
